// File: rtl/alu_pkg.sv
// Shared encodings and the fixed operand table for the ALU LED demonstrator.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOR = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_SLT = 3'b110,
        OP_SLL = 3'b111
    } alu_op_e;

    localparam logic [2:0] DISP_B0    = 3'b000;
    localparam logic [2:0] DISP_B1    = 3'b001;
    localparam logic [2:0] DISP_B2    = 3'b010;
    localparam logic [2:0] DISP_B3    = 3'b011;
    localparam logic [2:0] DISP_FLAGS = 3'b100;

    // Operand pairs chosen to exercise sign, overflow and carry corners.
    localparam logic [31:0] OPER_A [8] = '{
        32'h0000_0000, 32'h0000_0003, 32'h8000_0000, 32'h7FFF_FFFF,
        32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678
    };
    localparam logic [31:0] OPER_B [8] = '{
        32'h0000_0000, 32'h0000_0607, 32'h8000_0000, 32'h7FFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3333_4444
    };

endpackage

// File: rtl/alu32.sv
// Purely combinational 32-bit, 8-operation ALU with zero/overflow/carry flags.
module alu32
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  op,
    output logic [31:0] F,
    output logic        ZF,
    output logic        OF,
    output logic        CF
);

    logic [32:0]        sum33;
    logic [32:0]        diff33;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    // The extra top bit holds the carry for ADD and the borrow for SUB.
    assign sum33  = {1'b0, A} + {1'b0, B};
    assign diff33 = {1'b0, A} - {1'b0, B};
    assign a_s    = A;
    assign b_s    = B;

    // Select the result; OF/CF are only meaningful for ADD and SUB.
    always_comb begin
        F  = 32'h0;
        OF = 1'b0;
        CF = 1'b0;
        case (alu_op_e'(op))
            OP_AND: F = A & B;
            OP_OR:  F = A | B;
            OP_XOR: F = A ^ B;
            OP_NOR: F = ~(A | B);
            OP_ADD: begin
                F  = sum33[31:0];
                CF = sum33[32];
                OF = (A[31] == B[31]) && (sum33[31] != A[31]);
            end
            OP_SUB: begin
                F  = diff33[31:0];
                CF = diff33[32];
                OF = (A[31] != B[31]) && (diff33[31] != A[31]);
            end
            OP_SLT: F = {31'h0, (a_s < b_s)};
            OP_SLL: F = B << A[4:0];
            default: F = 32'h0;
        endcase
    end

    assign ZF = (F == 32'h0);

endmodule

// File: rtl/alu_led_top.sv
// Board wrapper: operand-table lookup, ALU, byte/flag display mux and LED register.
module alu_led_top
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] alu_op,
    input  logic [2:0] ab_sw,
    input  logic [2:0] c_led_sw,
    output logic [7:0] led
);

    logic [31:0] oper_a;
    logic [31:0] oper_b;
    logic [31:0] alu_f;
    logic        alu_zf;
    logic        alu_of;
    logic        alu_cf;
    logic [7:0]  led_d;
    logic [7:0]  led_q;

    assign oper_a = OPER_A[ab_sw];
    assign oper_b = OPER_B[ab_sw];

    alu32 u_alu32 (
        .A  (oper_a),
        .B  (oper_b),
        .op (alu_op),
        .F  (alu_f),
        .ZF (alu_zf),
        .OF (alu_of),
        .CF (alu_cf)
    );

    // Pick one result byte or the packed flags for the LEDs.
    always_comb begin
        led_d = 8'h00;
        case (c_led_sw)
            DISP_B0:    led_d = alu_f[7:0];
            DISP_B1:    led_d = alu_f[15:8];
            DISP_B2:    led_d = alu_f[23:16];
            DISP_B3:    led_d = alu_f[31:24];
            DISP_FLAGS: led_d = {5'b0, alu_cf, alu_of, alu_zf};
            default:    led_d = 8'h00;
        endcase
    end

    // LED register: one cycle of latency, cleared while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 8'h00;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_alu_led_top.sv
// Self-checking bench for alu_led_top: directed corner vectors plus randomized
// switch settings compared against an arithmetic reference model.
module tb_alu_led_top;

    logic       clk;
    logic       rst;
    logic [2:0] alu_op;
    logic [2:0] ab_sw;
    logic [2:0] c_led_sw;
    logic [7:0] led;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [31:0] TA [8] = '{
        32'h00000000, 32'h00000003, 32'h80000000, 32'h7FFFFFFF,
        32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678
    };
    localparam logic [31:0] TB [8] = '{
        32'h00000000, 32'h00000607, 32'h80000000, 32'h7FFFFFFF,
        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h33334444
    };

    alu_led_top dut (
        .clk      (clk),
        .rst      (rst),
        .alu_op   (alu_op),
        .ab_sw    (ab_sw),
        .c_led_sw (c_led_sw),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic over the operand table.
    function automatic logic [7:0] model_led(input int op, input int ab, input int sw);
        longint unsigned ua, ub, f, mask;
        longint          sa, sb, exact;
        int              ia, ib;
        bit              zf, of, cf;
        mask  = 64'h0000_0000_FFFF_FFFF;
        ua    = {32'h0, TA[ab]};
        ub    = {32'h0, TB[ab]};
        ia    = TA[ab];
        ib    = TB[ab];
        sa    = ia;
        sb    = ib;
        of    = 0;
        cf    = 0;
        f     = 0;
        exact = 0;
        case (op)
            0: f = ua & ub;
            1: f = ua | ub;
            2: f = ua ^ ub;
            3: f = (~(ua | ub)) & mask;
            4: begin
                f     = ua + ub;
                cf    = (f > mask);
                f     = f & mask;
                exact = sa + sb;
                of    = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
            end
            5: begin
                cf    = (ua < ub);
                f     = (ua - ub) & mask;
                exact = sa - sb;
                of    = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
            end
            6: f = (sa < sb) ? 64'd1 : 64'd0;
            default: f = (ub << (ua % 32)) & mask;
        endcase
        zf = (f == 0);
        if (sw < 4)       return 8'((f >> (8 * sw)) & 64'hFF);
        else if (sw == 4) return {5'b0, cf, of, zf};
        else              return 8'h00;
    endfunction

    task automatic drive(input int op, input int ab, input int sw);
        alu_op   = 3'(op);
        ab_sw    = 3'(ab);
        c_led_sw = 3'(sw);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1;
        drive(4, 3, 3);
        tick();
        total_cnt++;
        if (led !== 8'h00)
            $display("FAIL reset_hold: led=%h expected=%h", led, 8'h00);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (led !== 8'h00)
            $display("FAIL reset_hold2: led=%h expected=%h", led, 8'h00);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        exp = 8'hFF;
        total_cnt++;
        if (led !== exp)
            $display("FAIL reset_release: led=%h expected=%h", led, exp);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        // op, ab, sw, expected led
        int vec [][4] = '{
            '{4, 1, 0, 8'h0A}, '{4, 1, 1, 8'h06}, '{4, 1, 4, 8'h00},
            '{4, 3, 3, 8'hFF}, '{4, 3, 4, 8'h02}, '{4, 3, 0, 8'hFE},
            '{4, 4, 4, 8'h04},
            '{5, 2, 0, 8'h00}, '{5, 2, 1, 8'h00}, '{5, 2, 2, 8'h00},
            '{5, 2, 3, 8'h00}, '{5, 2, 4, 8'h01},
            '{0, 7, 1, 8'h44}, '{0, 7, 3, 8'h12},
            '{6, 5, 0, 8'h01}, '{6, 6, 0, 8'h00}, '{6, 6, 4, 8'h01},
            '{7, 7, 3, 8'h44}, '{7, 7, 0, 8'h00},
            '{3, 0, 0, 8'hFF}, '{3, 0, 1, 8'hFF}, '{3, 0, 2, 8'hFF},
            '{3, 0, 3, 8'hFF}, '{3, 0, 5, 8'h00}, '{3, 0, 7, 8'h00},
            '{5, 1, 4, 8'h04}, '{5, 5, 4, 8'h04}
        };
        foreach (vec[i]) begin
            drive(vec[i][0], vec[i][1], vec[i][2]);
            tick();
            total_cnt++;
            if (led !== 8'(vec[i][3]))
                $display("FAIL directed[%0d] op=%0d ab=%0d sw=%0d: led=%h expected=%h",
                         i, vec[i][0], vec[i][1], vec[i][2], led, 8'(vec[i][3]));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int op, ab, sw;
        logic [7:0] exp;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 7);
            ab = $urandom_range(0, 7);
            sw = $urandom_range(0, 7);
            drive(op, ab, sw);
            tick();
            exp = model_led(op, ab, sw);
            total_cnt++;
            if (led !== exp)
                $display("FAIL random op=%0d ab=%0d sw=%0d: led=%h expected=%h",
                         op, ab, sw, led, exp);
            else pass_cnt++;
        end
    endtask

    // Inputs changed mid-cycle must not reach led until the next edge.
    task automatic test_back_to_back();
        int op, ab, sw;
        logic [7:0] prev_exp, exp;
        op = $urandom_range(0, 7);
        ab = $urandom_range(0, 7);
        sw = $urandom_range(0, 4);
        drive(op, ab, sw);
        tick();
        prev_exp = model_led(op, ab, sw);
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 7);
            ab = $urandom_range(0, 7);
            sw = $urandom_range(0, 4);
            drive(op, ab, sw);
            #2;
            total_cnt++;
            if (led !== prev_exp)
                $display("FAIL hold_between_edges n=%0d: led=%h expected=%h", n, led, prev_exp);
            else pass_cnt++;
            tick();
            exp = model_led(op, ab, sw);
            total_cnt++;
            if (led !== exp)
                $display("FAIL back_to_back n=%0d op=%0d ab=%0d sw=%0d: led=%h expected=%h",
                         n, op, ab, sw, led, exp);
            else pass_cnt++;
            prev_exp = exp;
        end
    endtask

    task automatic test_reset_midstream();
        int op, ab, sw;
        logic [7:0] exp;
        for (int n = 0; n < 10; n++) begin
            op = $urandom_range(0, 7);
            ab = $urandom_range(0, 7);
            sw = $urandom_range(0, 4);
            drive(3, 0, 0);
            tick();
            rst = 1'b1;
            drive(op, ab, sw);
            tick();
            total_cnt++;
            if (led !== 8'h00)
                $display("FAIL mid_reset n=%0d: led=%h expected=%h", n, led, 8'h00);
            else pass_cnt++;
            rst = 1'b0;
            tick();
            exp = model_led(op, ab, sw);
            total_cnt++;
            if (led !== exp)
                $display("FAIL mid_reset_release n=%0d: led=%h expected=%h", n, led, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
